// File: rtl/decode_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_pkg
// Description : Shared instruction field positions, format codes and the
//               skid-buffer state encoding for the decode stage.
//               Instructions are numbered big-endian: bit 0 is the MSB.
// Revision    : 1.0 - initial release
// ============================================================================
package decode_stage_pkg;

  localparam int c_instr_w = 32;

  // Field positions (inclusive, ascending; lowest index is the field MSB)
  localparam int c_opc_first  = 0;
  localparam int c_opc_last   = 5;
  localparam int c_regs_first = 6;
  localparam int c_regs_last  = 10;
  localparam int c_regt_first = 11;
  localparam int c_regt_last  = 15;
  localparam int c_regd_first = 16;
  localparam int c_regd_last  = 20;
  localparam int c_immi_first = 16;
  localparam int c_immi_last  = 31;
  localparam int c_immj_first = 6;
  localparam int c_immj_last  = 31;

  localparam int c_opc_w  = c_opc_last  - c_opc_first  + 1;
  localparam int c_reg_w  = c_regs_last - c_regs_first + 1;
  localparam int c_immi_w = c_immi_last - c_immi_first + 1;
  localparam int c_immj_w = c_immj_last - c_immj_first + 1;

  // Opcodes that select the non-I formats
  localparam logic [5:0] c_opc_r   = 6'd0;
  localparam logic [5:0] c_opc_j   = 6'd2;
  localparam logic [5:0] c_opc_jal = 6'd3;

  typedef enum logic [1:0] {
    FMT_R = 2'd0,
    FMT_I = 2'd1,
    FMT_J = 2'd2
  } fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // main register invalid
    ST_ONE   = 2'd1,  // main valid, skid empty
    ST_FULL  = 2'd2   // main and skid both valid
  } state_e;

endpackage
`default_nettype wire

// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_if
// Description : Upstream (instruction) and downstream (decoded entry)
//               valid/ready channels of the decode stage.
//               slave  : view taken by decode_stage
//               master : view taken by the surrounding pipeline / bench
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_stage_if #(
  parameter int DATA_W = 32
);
  // upstream channel
  logic              in_valid;
  logic              in_ready;
  logic [0:31]       in_instr;
  // downstream channel
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_fmt;
  logic [5:0]        out_opcode;
  logic [DATA_W-1:0] out_dest;
  logic [DATA_W-1:0] out_opA;
  logic [DATA_W-1:0] out_opB;

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_fmt, out_opcode, out_dest, out_opA, out_opB
  );

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_fmt, out_opcode, out_dest, out_opA, out_opB
  );
endinterface
`default_nettype wire

// File: rtl/decode_stage_instr_field_decode.sv
`default_nettype none
// ============================================================================
// Module      : instr_field_decode
// Description : Combinational R/I/J classification and operand extraction.
//   i_instr  : instruction, bit 0 = MSB
//   o_fmt    : FMT_R / FMT_I / FMT_J
//   o_opcode : opcode field
//   o_dest   : destination field, zero-extended (0 for J)
//   o_opa    : operand A (J_OPA for J)
//   o_opb    : operand B (REGD, or extended IMMI / IMMJ)
// Revision    : 1.0 - initial release
// ============================================================================
module instr_field_decode
  import decode_stage_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter bit IMM_SIGNED = 1'b1,
  parameter int J_OPA      = -2
) (
  input  wire logic [0:c_instr_w-1] i_instr,
  output logic [1:0]                o_fmt,
  output logic [5:0]                o_opcode,
  output logic [DATA_W-1:0]         o_dest,
  output logic [DATA_W-1:0]         o_opa,
  output logic [DATA_W-1:0]         o_opb
);

  // Sign of the int parameter carries into the full operand width
  localparam logic [DATA_W-1:0] c_j_opa = DATA_W'(J_OPA);

  logic [c_opc_w-1:0]  w_opc;
  logic [c_reg_w-1:0]  w_regs;
  logic [c_reg_w-1:0]  w_regt;
  logic [c_reg_w-1:0]  w_regd;
  logic [c_immi_w-1:0] w_immi;
  logic [c_immj_w-1:0] w_immj;
  logic [DATA_W-1:0]   w_immi_ext;
  logic [DATA_W-1:0]   w_immj_ext;

  // Ascending part-selects keep the lowest-numbered bit as the field MSB
  assign w_opc  = i_instr[c_opc_first:c_opc_last];
  assign w_regs = i_instr[c_regs_first:c_regs_last];
  assign w_regt = i_instr[c_regt_first:c_regt_last];
  assign w_regd = i_instr[c_regd_first:c_regd_last];
  assign w_immi = i_instr[c_immi_first:c_immi_last];
  assign w_immj = i_instr[c_immj_first:c_immj_last];

  assign w_immi_ext = {{(DATA_W-c_immi_w){IMM_SIGNED & w_immi[c_immi_w-1]}}, w_immi};
  assign w_immj_ext = {{(DATA_W-c_immj_w){IMM_SIGNED & w_immj[c_immj_w-1]}}, w_immj};

  always_comb begin
    o_opcode = w_opc;
    o_fmt    = FMT_I;
    o_dest   = {{(DATA_W-c_reg_w){1'b0}}, w_regs};
    o_opa    = {{(DATA_W-c_reg_w){1'b0}}, w_regt};
    o_opb    = w_immi_ext;
    if (w_opc == c_opc_r) begin
      o_fmt = FMT_R;
      o_opb = {{(DATA_W-c_reg_w){1'b0}}, w_regd};
    end else if ((w_opc == c_opc_j) || (w_opc == c_opc_jal)) begin
      o_fmt  = FMT_J;
      o_dest = '0;
      o_opa  = c_j_opa;
      o_opb  = w_immj_ext;
    end
  end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : Registered instruction-decode stage with a 2-entry skid
//               buffer; one instruction per cycle, registered in_ready.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   flush : synchronous discard of all held entries
//   bus   : slave view of decode_stage_if (in_* upstream, out_* downstream)
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter bit IMM_SIGNED = 1'b1,
  parameter int J_OPA      = -2
) (
  input wire logic     clk,
  input wire logic     rst_n,
  input wire logic     flush,
  decode_stage_if.slave bus
);

  localparam int c_ent_w = 2 + c_opc_w + 3 * DATA_W;

  state_e               r_state;
  state_e               w_state_nxt;
  logic                 r_in_ready;
  logic [c_ent_w-1:0]   r_main;
  logic [c_ent_w-1:0]   r_skid;
  logic [c_ent_w-1:0]   w_dec;
  logic                 w_in_xfer;
  logic                 w_out_xfer;
  logic                 w_load_main_in;
  logic                 w_load_main_skid;
  logic                 w_load_skid;

  logic [1:0]           w_fmt;
  logic [5:0]           w_opc;
  logic [DATA_W-1:0]    w_dest;
  logic [DATA_W-1:0]    w_opa;
  logic [DATA_W-1:0]    w_opb;

  instr_field_decode #(
    .DATA_W     (DATA_W),
    .IMM_SIGNED (IMM_SIGNED),
    .J_OPA      (J_OPA)
  ) u_decode (
    .i_instr  (bus.in_instr),
    .o_fmt    (w_fmt),
    .o_opcode (w_opc),
    .o_dest   (w_dest),
    .o_opa    (w_opa),
    .o_opb    (w_opb)
  );

  assign w_dec      = {w_fmt, w_opc, w_dest, w_opa, w_opb};
  assign w_in_xfer  = bus.in_valid & r_in_ready;
  assign w_out_xfer = (r_state != ST_EMPTY) & bus.out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_state_nxt    = ST_ONE;
          w_load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        case ({w_in_xfer, w_out_xfer})
          2'b11:   w_load_main_in = 1'b1;
          2'b10: begin
            w_state_nxt = ST_FULL;
            w_load_skid = 1'b1;
          end
          2'b01:   w_state_nxt = ST_EMPTY;
          default: ;
        endcase
      end
      ST_FULL: begin
        // in_ready is low here, so nothing new can arrive this cycle
        if (w_out_xfer) begin
          w_state_nxt      = ST_ONE;
          w_load_main_skid = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    // Flush drops everything, including an instruction accepted this cycle;
    // stored data is left untouched since it is invalid afterwards.
    if (flush) begin
      w_state_nxt      = ST_EMPTY;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  // in_ready is the registered image of the next state, so out_ready has no
  // combinational path to it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main <= w_dec;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_dec;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = (r_state != ST_EMPTY);
  assign {bus.out_fmt, bus.out_opcode, bus.out_dest, bus.out_opA, bus.out_opB} = r_main;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Self-checking bench for decode_stage. Two instances share
//               one stimulus stream: dut_a (64-bit, sign-extending) and
//               dut_b (32-bit, zero-extending). Expected entries are queued
//               at acceptance and compared while they sit at the output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        flush     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [0:31] in_instr  = '0;

  always #5 clk = ~clk;

  decode_stage_if #(.DATA_W(64)) bus_a ();
  decode_stage_if #(.DATA_W(32)) bus_b ();

  assign bus_a.in_valid  = in_valid;
  assign bus_a.in_instr  = in_instr;
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_instr  = in_instr;
  assign bus_b.out_ready = out_ready;

  decode_stage #(.DATA_W(64), .IMM_SIGNED(1'b1), .J_OPA(-2)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_a)
  );
  decode_stage #(.DATA_W(32), .IMM_SIGNED(1'b0), .J_OPA(-2)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_b)
  );

  typedef struct {
    logic [1:0]  fmt;
    logic [5:0]  opc;
    logic [63:0] dest;
    logic [63:0] opa_a;
    logic [63:0] opb_a;
    logic [31:0] opa_b;
    logic [31:0] opb_b;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          n      = 0;   // model occupancy: 0 EMPTY, 1 ONE, 2 FULL
  exp_t        sb[$];
  logic [0:31] pending[$];

  function automatic logic [0:31] mk(logic [5:0] opc, logic [25:0] rest);
    logic [0:31] v;
    v = {opc, rest};
    return v;
  endfunction

  function automatic exp_t model(logic [0:31] ins);
    exp_t        e;
    logic [5:0]  opc;
    logic [15:0] ii;
    logic [25:0] jj;
    opc   = ins[0:5];
    ii    = ins[16:31];
    jj    = ins[6:31];
    e.opc = opc;
    if (opc == 6'd0) begin
      e.fmt   = 2'd0;
      e.dest  = {59'd0, ins[6:10]};
      e.opa_a = {59'd0, ins[11:15]};
      e.opb_a = {59'd0, ins[16:20]};
      e.opa_b = {27'd0, ins[11:15]};
      e.opb_b = {27'd0, ins[16:20]};
    end else if (opc == 6'd2 || opc == 6'd3) begin
      e.fmt   = 2'd2;
      e.dest  = 64'd0;
      e.opa_a = 64'hFFFF_FFFF_FFFF_FFFE;
      e.opb_a = {{38{jj[25]}}, jj};
      e.opa_b = 32'hFFFF_FFFE;
      e.opb_b = {6'd0, jj};
    end else begin
      e.fmt   = 2'd1;
      e.dest  = {59'd0, ins[6:10]};
      e.opa_a = {59'd0, ins[11:15]};
      e.opb_a = {{48{ii[15]}}, ii};
      e.opa_b = {27'd0, ins[11:15]};
      e.opb_b = {16'd0, ii};
    end
    return e;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_valid_a"}, bus_a.out_valid,  0);
    chk({tag, "_ready_a"}, bus_a.in_ready,   1);
    chk({tag, "_fmt_a"},   bus_a.out_fmt,    0);
    chk({tag, "_opc_a"},   bus_a.out_opcode, 0);
    chk({tag, "_dest_a"},  bus_a.out_dest,   0);
    chk({tag, "_opa_a"},   bus_a.out_opA,    0);
    chk({tag, "_opb_a"},   bus_a.out_opB,    0);
    chk({tag, "_valid_b"}, bus_b.out_valid,  0);
    chk({tag, "_ready_b"}, bus_b.in_ready,   1);
    chk({tag, "_opb_b"},   {32'd0, bus_b.out_opB}, 0);
  endtask

  // One clock: present the next pending instruction, check handshake and
  // the head entry, then advance the model across the edge.
  task automatic cycle();
    bit          in_x;
    bit          out_x;
    logic [0:31] cur;
    in_valid = (pending.size() > 0);
    cur      = in_valid ? pending[0] : 32'hDEAD_BEEF;
    in_instr = cur;
    #1;
    chk("in_ready_a",  bus_a.in_ready,  (n != 2));
    chk("in_ready_b",  bus_b.in_ready,  (n != 2));
    chk("out_valid_a", bus_a.out_valid, (n != 0));
    chk("out_valid_b", bus_b.out_valid, (n != 0));
    if (n > 0) begin
      chk("fmt_a",  bus_a.out_fmt,    sb[0].fmt);
      chk("opc_a",  bus_a.out_opcode, sb[0].opc);
      chk("dest_a", bus_a.out_dest,   sb[0].dest);
      chk("opa_a",  bus_a.out_opA,    sb[0].opa_a);
      chk("opb_a",  bus_a.out_opB,    sb[0].opb_a);
      chk("fmt_b",  bus_b.out_fmt,    sb[0].fmt);
      chk("dest_b", {32'd0, bus_b.out_dest}, sb[0].dest);
      chk("opa_b",  {32'd0, bus_b.out_opA},  {32'd0, sb[0].opa_b});
      chk("opb_b",  {32'd0, bus_b.out_opB},  {32'd0, sb[0].opb_b});
    end
    in_x  = in_valid && (n != 2);
    out_x = (n > 0) && out_ready && !flush;
    @(posedge clk);
    #1;
    if (in_x) void'(pending.pop_front());
    if (flush) begin
      sb.delete();
      n = 0;
    end else begin
      if (out_x) void'(sb.pop_front());
      if (in_x) sb.push_back(model(cur));
      if (in_x && !out_x) n++;
      else if (!in_x && out_x) n--;
    end
  endtask

  task automatic run(int k, bit ordy);
    out_ready = ordy;
    repeat (k) cycle();
  endtask

  initial begin
    // Reset, checked while asserted and after release with the stage idle
    #12;
    chk_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run(2, 1'b1);
    chk_reset("idle");

    // R, I (negative and positive imm), J (small and negative immj)
    pending.push_back(mk(6'd0, {5'd3, 5'd4, 5'd5, 11'd0}));
    run(3, 1'b1);
    pending.push_back(mk(6'd8, {5'd1, 5'd2, 16'h8000}));
    pending.push_back(mk(6'd9, {5'd7, 5'd31, 16'h1234}));
    run(4, 1'b1);
    pending.push_back(mk(6'd2, 26'h000_0100));
    pending.push_back(mk(6'd3, 26'h200_0001));
    run(4, 1'b1);

    // A, B, C with downstream stalled: C is held until space frees
    pending.push_back(mk(6'd0,  {5'd10, 5'd11, 5'd12, 11'd0}));
    pending.push_back(mk(6'd12, {5'd13, 5'd14, 16'hFFFF}));
    pending.push_back(mk(6'd2,  26'h3FF_FFFF));
    run(3, 1'b0);
    run(5, 1'b1);

    // Flush while FULL, then D comes out first
    pending.push_back(mk(6'd4, {5'd1, 5'd1, 16'h0001}));
    pending.push_back(mk(6'd5, {5'd2, 5'd2, 16'h0002}));
    run(2, 1'b0);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    pending.push_back(mk(6'd0, {5'd20, 5'd21, 5'd22, 11'd0}));
    run(3, 1'b1);

    // Flush while ONE with an instruction presented: it is discarded
    pending.push_back(mk(6'd6, {5'd3, 5'd3, 16'h0003}));
    run(1, 1'b0);
    pending.push_back(mk(6'd7, {5'd4, 5'd4, 16'h0004}));
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    run(2, 1'b1);

    // Random stream with random backpressure
    for (int i = 0; i < 24; i++) begin
      pending.push_back(mk(6'($urandom_range(0, 7)), 26'($urandom)));
    end
    for (int i = 0; i < 40; i++) begin
      run(1, 1'($urandom_range(0, 1)));
    end
    run(30, 1'b1);

    // Asynchronous reset mid-operation
    pending.push_back(mk(6'd0, {5'd9, 5'd9, 5'd9, 11'd0}));
    pending.push_back(mk(6'd10, {5'd8, 5'd8, 16'h8888}));
    run(2, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("async_rst");
    n = 0;
    sb.delete();
    pending.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run(2, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
